// File: rtl/fir_pkg.sv
// Shared types and constants for the 4-tap FIR sequencing controller:
// FSM states, datapath opcodes, register-file map and the output decoder.
package fir_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOADC = 4'd1,
    ST_STORE = 4'd2,
    ST_SHIFT = 4'd3,
    ST_ZERO  = 4'd4,
    ST_MUL   = 4'd5,
    ST_ACC   = 4'd6,
    ST_DONE  = 4'd7,
    ST_EIDLE = 4'd8
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_COPY  = 3'b001;
  localparam logic [2:0] OP_LOAD1 = 3'b010;
  localparam logic [2:0] OP_LOAD2 = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;

  localparam logic [3:0] R_RESULT = 4'd0;
  localparam logic [3:0] R_WIN0   = 4'd1;
  localparam logic [3:0] R_SAMPLE = 4'd5;
  localparam logic [3:0] R_COEFF0 = 4'd6;
  localparam logic [3:0] R_PROD   = 4'd10;

  typedef struct packed {
    logic       modwait;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       cnt_up;
    logic       err;
  } ctrl_t;

  // Moore decode of the control word for a given state, index and latched coefficient number.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [1:0] idx,
                                        input logic [1:0] cnum);
    ctrl_t c;
    c = '0;
    case (st)
      ST_IDLE: begin
        c = '0;
      end
      ST_LOADC: begin
        c.modwait = 1'b1;
        c.op      = OP_LOAD2;
        c.dest    = R_COEFF0 + {2'b00, cnum};
      end
      ST_STORE: begin
        c.modwait = 1'b1;
        c.op      = OP_LOAD1;
        c.dest    = R_SAMPLE;
      end
      ST_SHIFT: begin
        c.modwait = 1'b1;
        c.op      = OP_COPY;
        if (idx == 2'd3) begin
          c.src1 = R_SAMPLE;
          c.dest = R_WIN0;
        end else begin
          c.src1 = 4'd3 - {2'b00, idx};
          c.dest = 4'd4 - {2'b00, idx};
        end
      end
      ST_ZERO: begin
        c.modwait = 1'b1;
        c.op      = OP_SUB;
        c.src1    = R_RESULT;
        c.src2    = R_RESULT;
        c.dest    = R_RESULT;
      end
      ST_MUL: begin
        c.modwait = 1'b1;
        c.op      = OP_MUL;
        c.src1    = R_WIN0 + {2'b00, idx};
        c.src2    = R_COEFF0 + {2'b00, idx};
        c.dest    = R_PROD;
      end
      ST_ACC: begin
        c.modwait = 1'b1;
        c.op      = OP_ADD;
        c.src1    = R_RESULT;
        c.src2    = R_PROD;
        c.dest    = R_RESULT;
      end
      ST_DONE: begin
        c.modwait = 1'b1;
        c.cnt_up  = 1'b1;
      end
      ST_EIDLE: begin
        c.err = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fir_controller.sv
// Sequencer for a 4-tap FIR datapath: loads coefficients, shifts the sample
// window and issues the multiply/accumulate opcode stream for each sample.
module fir_controller
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       dr,
  input  logic       load_coeff,
  input  logic [1:0] coefficient_num,
  input  logic       overflow,
  output logic       modwait,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       cnt_up,
  output logic       err
);

  state_t     state_r, state_s;
  logic [1:0] idx_r, idx_s;
  logic [1:0] cnum_r, cnum_s;
  ctrl_t      ctrl_r, ctrl_s;

  // State, index, coefficient number and output register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      cnum_r  <= 2'd0;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnum_r  <= cnum_s;
      ctrl_r  <= ctrl_s;
    end
  end

  // Next-state and index logic; idx only returns to 0 through an explicit reload.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnum_s  = cnum_r;
    case (state_r)
      ST_IDLE, ST_EIDLE: begin
        if (load_coeff) begin
          state_s = ST_LOADC;
          cnum_s  = coefficient_num;
        end else if (dr) begin
          state_s = ST_STORE;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOADC: begin
        state_s = ST_IDLE;
      end
      ST_STORE: begin
        if (!dr) begin
          state_s = ST_EIDLE;
        end else begin
          state_s = ST_SHIFT;
          idx_s   = 2'd0;
        end
      end
      ST_SHIFT: begin
        if (idx_r == 2'd3) begin
          state_s = ST_ZERO;
        end else begin
          idx_s = idx_r + 2'd1;
        end
      end
      ST_ZERO: begin
        state_s = ST_MUL;
        idx_s   = 2'd0;
      end
      ST_MUL: begin
        state_s = ST_ACC;
      end
      ST_ACC: begin
        if (overflow) begin
          state_s = ST_EIDLE;
        end else if (idx_r != 2'd3) begin
          state_s = ST_MUL;
          idx_s   = idx_r + 2'd1;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 2'd0;
      end
    endcase
  end

  // Outputs are registered from the decode of the next state, so they track the current state.
  always_comb begin
    ctrl_s = decode_ctrl(state_s, idx_s, cnum_s);
  end

  assign modwait = ctrl_r.modwait;
  assign op      = ctrl_r.op;
  assign src1    = ctrl_r.src1;
  assign src2    = ctrl_r.src2;
  assign dest    = ctrl_r.dest;
  assign cnt_up  = ctrl_r.cnt_up;
  assign err     = ctrl_r.err;

endmodule
